// File: rtl/bitstream_pkg.sv
// Shared widths and small helpers for the bit packer/unpacker/decoder family.
package bitstream_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BUF_W  = 48;
    localparam int unsigned MAXLEN = 16;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned LEN_W  = 5;

    typedef logic [BUF_W-1:0]  buf_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [LEN_W-1:0]  len_t;

    // Room for one more word only while the buffer holds at most BUF_W - WORD_W bits.
    localparam cnt_t ACCEPT_MAX = cnt_t'(BUF_W - WORD_W);

    function automatic logic take_legal(input logic take, input len_t tlen, input cnt_t cnt);
        return take && (tlen <= len_t'(MAXLEN)) && (cnt_t'(tlen) <= cnt);
    endfunction

endpackage

// File: rtl/bitstream_unpack_shift.sv
// Buffer datapath: drop n consumed bits, then OR the accepted word in just above the survivors.
module bitstream_unpack_shift
    import bitstream_pkg::*;
(
    input  logic [BUF_W-1:0]  buf_q,
    input  logic [LEN_W-1:0]  n,
    input  logic              acc,
    input  logic [WORD_W-1:0] idata,
    input  logic [CNT_W-1:0]  cnt,
    output logic [BUF_W-1:0]  buf_next
);

    logic [BUF_W-1:0] s1, s2, s4, s8, s16;
    logic [BUF_W-1:0] ins;
    logic [CNT_W-1:0] ins_off;

    always_comb begin
        s1  = n[0] ? (buf_q >> 1)  : buf_q;
        s2  = n[1] ? (s1    >> 2)  : s1;
        s4  = n[2] ? (s2    >> 4)  : s2;
        s8  = n[3] ? (s4    >> 8)  : s4;
        s16 = n[4] ? (s8    >> 16) : s8;

        // Bits above cnt are zero, so a plain OR places the word without masking.
        ins_off  = cnt - CNT_W'(n);
        ins      = acc ? (BUF_W'(idata) << ins_off) : '0;
        buf_next = s16 | ins;
    end

endmodule

// File: rtl/bitstream_unpack.sv
// Variable-length LSB-first bitstream reader: 16-bit words in, 0..16 bits taken per cycle.
module bitstream_unpack
    import bitstream_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ivalid,
    input  logic [WORD_W-1:0] idata,
    output logic              iready,
    output logic [WORD_W-1:0] odata,
    output logic [CNT_W-1:0]  level,
    input  logic              take,
    input  logic [LEN_W-1:0]  tlen,
    output logic [2:0]        rest,
    output logic              err
);

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       ph;
    logic             err_q;
    logic             legal;
    logic             acc;
    logic [LEN_W-1:0] n;

    always_comb begin
        legal    = take_legal(take, tlen, cnt);
        n        = legal ? tlen : '0;
        iready   = (cnt <= ACCEPT_MAX) && rst_n;
        acc      = ivalid && iready;
        cnt_next = cnt - CNT_W'(n) + (acc ? CNT_W'(WORD_W) : '0);
        odata    = buf_q[WORD_W-1:0];
        level    = cnt;
        rest     = 3'd0 - ph;
        err      = err_q;
    end

    bitstream_unpack_shift u_shift (
        .buf_q    (buf_q),
        .n        (n),
        .acc      (acc),
        .idata    (idata),
        .cnt      (cnt),
        .buf_next (buf_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt   <= '0;
            ph    <= '0;
            err_q <= 1'b0;
        end else begin
            buf_q <= buf_next;
            cnt   <= cnt_next;
            ph    <= ph + n[2:0];
            if (take && !legal)
                err_q <= 1'b1;
        end
    end

endmodule

// File: doc/bitstream_unpack.md
# bitstream_unpack

Variable-length bitstream reader: accepts 16-bit packed words and hands a downstream decoder 0..16 bits per cycle, LSB-first. It is the read side of the team's bit packer, which places code bits contiguously from bit 0 of each 16-bit word upward. It sits between the capture/DMA word stream and the code decoder (Huffman/VLC) in the decode path. Bit `16k+j` of the stream is bit `j` of input word `k`.

## Interface
Parameters:
- None. Widths are fixed in `bitstream_pkg`.

Ports (clock and reset first):
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `ivalid` input 1: `idata` holds a packed word.
- `idata` input 16: packed word; bit 0 is the earliest stream bit.
- `iready` output 1: word accepted on a cycle where `ivalid && iready`.
- `odata` output 16: peek window, the next 16 unconsumed stream bits, LSB = next bit. Bits at or above `level` read 0.
- `level` output 6: number of valid buffered bits, 0..48.
- `take` input 1: consume `tlen` bits this cycle.
- `tlen` input 5: number of bits to consume, 0..16.
- `rest` output 3: bits remaining to the next byte boundary of the consumed stream, equal to `(-consumed_total) mod 8`.
- `err` output 1: sticky illegal-take flag.

## Operation
- **Storage:** 48-bit buffer `buf`, 6-bit count `cnt`, 3-bit byte-phase counter `ph`, and the `err` register.
- **Combinational outputs:** `odata = buf[15:0]`, `level = cnt`, `rest = -ph`, `iready = (cnt <= 32) && rst_n`. `iready` never depends on `take`/`tlen` in the same cycle.
- **Legal take:** `take && tlen <= 16 && tlen <= cnt`. Define `n = tlen` for a legal take, otherwise `n = 0`.
- **Accept:** `acc = ivalid && iready`.
- **Next-state update:**
  - `buf_next = (buf >> n) | (acc ? idata << (cnt - n) : 0)`.
  - `cnt_next = cnt - n + (acc ? 16 : 0)`, always ≤ 48.
  - `ph_next = ph + n[2:0]`.
- **Zero invariant:** bits of `buf` at or above `cnt` are always 0. This keeps `odata` zero-padded.
- **Illegal take:** `take && (tlen > 16 || tlen > cnt)` consumes nothing and sets `err`. `err` clears only on reset. An accept in the same cycle still proceeds.
- **`tlen == 0` take:** legal no-op.
- **Reset** (`rst_n` low at an edge): `buf = 0`, `cnt = 0`, `ph = 0`, `err = 0`. `iready` is low during the reset cycle; input and take are ignored. This applies identically mid-stream; all buffered bits are discarded.

## Timing
- **Peek latency:** 0. `odata` reflects register state in the same cycle the consumer samples it.
- **Take effect:** `odata`, `level` and `rest` update on the edge of the take, and are visible the next cycle.
- **Input latency:** a word accepted at edge `t` is visible in `odata`/`level` from cycle `t+1`.
- **Throughput:** one 16-bit word in and one take of up to 16 bits per cycle, sustained.
- **Full boundary:** at `cnt` 33..48, `iready = 0`. Once a take brings `cnt` to ≤ 32, `iready` rises the following cycle, giving one bubble.
- **Empty boundary:** with `cnt = 0`, any take with `tlen > 0` is illegal.

## Structure
- **`bitstream_pkg`:** holds `WORD_W = 16`, `BUF_W = 48`, `MAXLEN = 16`, `CNT_W = 6`, `LEN_W = 5`. Shared with the packer and the decoder.
- **Sub-module `bitstream_unpack_shift`:** combinational 48-bit right shift by `n` (staged 1/2/4/8/16) and OR-insert of `idata` at offset `cnt - n`.
- **Top level:** count/phase/err registers, legality check, and handshake.

## Test plan
- **Reset:** hold `rst_n = 0` for 2 cycles with `ivalid = 1`, then release → `level = 0`, `odata = 0`, `rest = 0`, `err = 0`. `iready = 0` while in reset and 1 after release.
- **Basic peek/take:** push `16'hA5C3`, then `take tlen = 4` → next cycle `odata = 16'h0A5C`, `level = 12`, `rest = 4`. Then take 12 → `level = 0`, `rest = 0`.
- **Simultaneous take and push:** at `level = 20`, take 5 and push `16'hFFFF` in the same cycle → `level = 31`, new bits occupy buffer positions 15..30. `odata` equals the old bits [20:5] with `[15]` set.
- **Full boundary:** push 3 words with no take → `level = 48`, `iready = 0`. Take 16 while `ivalid = 1` → `level = 32`, word not accepted. `iready = 1` the next cycle.
- **Illegal take:** at `level = 3`, take 8 → `level` stays 3, `err = 1`. A later legal take 3 works; `err` stays 1 until reset.
- **Round trip:** random codes of length 0..16 (including 16 and runs of 0) packed by the team's packer, unpacked with the same length sequence → every taken field `odata & mask(tlen)` matches the original code. `rest` matches the packer's `rest` at equal bit counts.
